dsi_packet_assembler: RTL and testbench
=======================================

# dsi_packet_assembler

Builds MIPI DSI short and long packets and feeds them byte-by-byte to the single-lane transmitter that sits directly downstream. It accepts a packet command (data ID, word count or short-packet data, mode flags) plus a payload byte stream, inserts the header ECC and payload CRC-16, and drives the lane's byte-write handshake with per-byte HS/LP, end-of-frame and dummy flags.

## Interface
- CRC_INIT, 16'hFFFF, CRC-16 seed loaded at the start of every long-packet payload
- clk_base  in  1  byte clock, same domain as the lane's logic clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  packet command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_di  in  8  data identifier (VC[7:6], DT[5:0])
- cmd_wc  in  16  long: payload byte count; short: {data1, data0}
- cmd_long  in  1  1 = long packet (payload + CRC), 0 = short packet
- cmd_hs  in  1  1 = HS transmission, 0 = LP; copied to lane_type for every byte of the packet
- cmd_last  in  1  packet ends the burst; its final byte carries lane_eof
- cmd_dummy  in  1  emit a single dummy byte instead of a packet
- pl_valid  in  1  payload byte valid
- pl_ready  out  1  payload byte consumed when pl_valid & pl_ready
- pl_data  in  8  payload byte
- lane_data  out  8  byte to lane
- lane_write  out  1  byte write strobe
- lane_type  out  1  0 = LP byte, 1 = HS byte
- lane_eof  out  1  last byte of burst
- lane_dummy  out  1  byte carries no valid data
- lane_ready  in  1  lane can take a byte this cycle
- busy  out  1  packet in progress (state != IDLE)
- err_underrun  out  1  one-cycle pulse: payload byte missing while lane ready

## Operation
- States: IDLE, DI, WC0, WC1, ECC, PAYLOAD, CRC0, CRC1, DUMMY.
- IDLE: cmd_ready=1. On accept, register all cmd_* fields; next state DUMMY if cmd_dummy else DI.
- A byte transfers when lane_write & lane_ready. lane_write = lane_ready & (state ∈ {DI,WC0,WC1,ECC,CRC0,CRC1,DUMMY} | (state==PAYLOAD & pl_valid)). State advances only on a transfer.
- Byte order: DI=cmd_di, WC0=cmd_wc[7:0], WC1=cmd_wc[15:8], ECC=ecc, PAYLOAD=pl_data, CRC0=crc[7:0], CRC1=crc[15:8]. DUMMY sends 8'h00 with lane_dummy=1, lane_eof=1.
- After ECC: short → IDLE; long with wc=0 → CRC0; else PAYLOAD. 16-bit byte counter loaded with wc, decremented per payload transfer; at 1 → CRC0. CRC1 → IDLE.
- ECC (P7=P6=0), D[23:0]={WC1,WC0,DI}:
  - P0=D0^D1^D2^D4^D5^D7^D10^D11^D13^D16^D20^D21^D22^D23
  - P1=D0^D1^D3^D4^D6^D8^D10^D12^D14^D17^D20^D21^D22^D23
  - P2=D0^D2^D3^D5^D6^D9^D11^D12^D15^D18^D20^D21^D22
  - P3=D1^D2^D3^D7^D8^D9^D13^D14^D15^D19^D20^D21^D23
  - P4=D4^D5^D6^D7^D8^D9^D16^D17^D18^D19^D20^D22^D23
  - P5=D10^D11^D12^D13^D14^D15^D16^D17^D18^D19^D21^D22^D23
- CRC: x^16+x^12+x^5+1, LSB-first (reflected 16'h8408), no final XOR; reset to CRC_INIT on command accept, updated per payload transfer (8 bit-steps in one cycle).
- lane_eof=cmd_last on the final byte (ECC for short, CRC1 for long), 0 otherwise. lane_type=cmd_hs on all bytes.
- Underrun: state PAYLOAD, lane_ready=1, pl_valid=0 → err_underrun pulses that cycle; no byte written, state holds.
- pl_ready = (state==PAYLOAD) & lane_ready.
- Back-to-back: cmd_ready also asserted in the final-byte state when that byte transfers; a command accepted then starts DI next cycle with no gap.

## Timing
- Reset: state IDLE, cmd_ready=1, pl_ready=0, lane_write=0, lane_data=0, lane_type/eof/dummy=0, busy=0, err_underrun=0, crc=CRC_INIT, counter=0.
- Command accepted cycle N → DI byte presented on cycle N+1 (lane_write if lane_ready).
- Outputs lane_* are combinational from registered state/fields and pl_data; pl_ready/lane_write are combinational from lane_ready (no registered stage).
- lane_ready low stalls any state indefinitely with all outputs held; no data loss.
- Reset mid-packet: immediate return to IDLE; partial packet abandoned, no further writes.
- Simultaneous cmd_valid in non-final states ignored (cmd_ready=0).

## Test plan
- Short packet DI=8'h01, wc=16'h0000, hs=1, last=1, lane_ready=1 → bytes 01,00,00,07 on 4 consecutive cycles, lane_eof only on 07, lane_type=1.
- Long packet DI=8'h39, wc=9, payload 31..39 ("123456789") → header 39,09,00,ECC, payload, then 91,6F; lane_eof on 6F.
- Long packet wc=0 → header, then FF,FF as CRC.
- Payload stall: deassert pl_valid for 3 cycles mid-payload with lane_ready=1 → 3 err_underrun pulses, no writes, CRC still correct after resume.
- lane_ready toggling every other cycle through a 9-byte long packet → identical byte sequence, no duplicates/drops; dummy command → single 00 byte with lane_dummy=1, lane_eof=1.
- Reset asserted during PAYLOAD → next cycle busy=0, lane_write=0, cmd_ready=1; following packet correct.

Source files
------------

// File: rtl/dsi_packet_assembler.sv
// MIPI DSI short/long packet builder: serialises header, ECC, payload and CRC-16
// onto a single-lane byte-write handshake.
module dsi_packet_assembler #(
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic        clk_base,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_di,
    input  logic [15:0] cmd_wc,
    input  logic        cmd_long,
    input  logic        cmd_hs,
    input  logic        cmd_last,
    input  logic        cmd_dummy,
    input  logic        pl_valid,
    output logic        pl_ready,
    input  logic [7:0]  pl_data,
    output logic [7:0]  lane_data,
    output logic        lane_write,
    output logic        lane_type,
    output logic        lane_eof,
    output logic        lane_dummy,
    input  logic        lane_ready,
    output logic        busy,
    output logic        err_underrun
);

    typedef enum logic [3:0] {
        StIdle,
        StDi,
        StWc0,
        StWc1,
        StEcc,
        StPayload,
        StCrc0,
        StCrc1,
        StDummy
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  di_q, di_d;
    logic [15:0] wc_q, wc_d;
    logic        long_q, long_d;
    logic        hs_q, hs_d;
    logic        last_q, last_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;

    logic [7:0]  ecc;
    logic        final_byte;

    // Hamming-style header ECC over {WC1, WC0, DI}; P7/P6 are always zero.
    function automatic logic [7:0] ecc_calc(input logic [23:0] d);
        ecc_calc = {2'b00,
                    ^(d & 24'hEFFC00),
                    ^(d & 24'hDF03F0),
                    ^(d & 24'hB8E38E),
                    ^(d & 24'h749A6D),
                    ^(d & 24'hF2555B),
                    ^(d & 24'hF12CB7)};
    endfunction

    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) begin
                c = c ^ 16'h8408;
            end
        end
        crc_byte = c;
    endfunction

    assign ecc        = ecc_calc({wc_q, di_q});
    assign final_byte = (state_q == StEcc && !long_q) || (state_q == StCrc1) ||
                        (state_q == StDummy);
    assign busy       = (state_q != StIdle);

    always_comb begin
        state_d      = state_q;
        di_d         = di_q;
        wc_d         = wc_q;
        long_d       = long_q;
        hs_d         = hs_q;
        last_d       = last_q;
        crc_d        = crc_q;
        cnt_d        = cnt_q;
        cmd_ready    = 1'b0;
        pl_ready     = 1'b0;
        lane_write   = 1'b0;
        lane_data    = 8'h00;
        lane_type    = busy ? hs_q : 1'b0;
        lane_eof     = 1'b0;
        lane_dummy   = 1'b0;
        err_underrun = 1'b0;

        unique case (state_q)
            StIdle: ;
            StDi: begin
                lane_write = lane_ready;
                lane_data  = di_q;
                if (lane_write) state_d = StWc0;
            end
            StWc0: begin
                lane_write = lane_ready;
                lane_data  = wc_q[7:0];
                if (lane_write) state_d = StWc1;
            end
            StWc1: begin
                lane_write = lane_ready;
                lane_data  = wc_q[15:8];
                if (lane_write) state_d = StEcc;
            end
            StEcc: begin
                lane_write = lane_ready;
                lane_data  = ecc;
                lane_eof   = !long_q && last_q;
                if (lane_write) begin
                    if (!long_q)           state_d = StIdle;
                    else if (wc_q == '0)   state_d = StCrc0;
                    else                   state_d = StPayload;
                end
            end
            StPayload: begin
                pl_ready     = lane_ready;
                lane_write   = lane_ready && pl_valid;
                lane_data    = pl_data;
                err_underrun = lane_ready && !pl_valid;
                if (lane_write) begin
                    crc_d = crc_byte(crc_q, pl_data);
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = StCrc0;
                end
            end
            StCrc0: begin
                lane_write = lane_ready;
                lane_data  = crc_q[7:0];
                if (lane_write) state_d = StCrc1;
            end
            StCrc1: begin
                lane_write = lane_ready;
                lane_data  = crc_q[15:8];
                lane_eof   = last_q;
                if (lane_write) state_d = StIdle;
            end
            StDummy: begin
                lane_write = lane_ready;
                lane_dummy = 1'b1;
                lane_eof   = 1'b1;
                if (lane_write) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Accepting while the last byte goes out lets the next DI follow with no gap.
        cmd_ready = (state_q == StIdle) || (final_byte && lane_write);
        if (cmd_valid && cmd_ready) begin
            di_d    = cmd_di;
            wc_d    = cmd_wc;
            long_d  = cmd_long;
            hs_d    = cmd_hs;
            last_d  = cmd_last;
            crc_d   = CRC_INIT;
            cnt_d   = cmd_wc;
            state_d = cmd_dummy ? StDummy : StDi;
        end
    end

    always_ff @(posedge clk_base or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            di_q    <= 8'h00;
            wc_q    <= 16'h0000;
            long_q  <= 1'b0;
            hs_q    <= 1'b0;
            last_q  <= 1'b0;
            crc_q   <= CRC_INIT;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            di_q    <= di_d;
            wc_q    <= wc_d;
            long_q  <= long_d;
            hs_q    <= hs_d;
            last_q  <= last_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Directed bench for dsi_packet_assembler: byte sequences, flags, handshakes, stalls, reset.
module tb_dsi_packet_assembler;

    logic        clk_base = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_di;
    logic [15:0] cmd_wc;
    logic        cmd_long;
    logic        cmd_hs;
    logic        cmd_last;
    logic        cmd_dummy;
    logic        pl_valid;
    logic        pl_ready;
    logic [7:0]  pl_data;
    logic [7:0]  lane_data;
    logic        lane_write;
    logic        lane_type;
    logic        lane_eof;
    logic        lane_dummy;
    logic        lane_ready;
    logic        busy;
    logic        err_underrun;

    always #5 clk_base = ~clk_base;

    dsi_packet_assembler dut (
        .clk_base     (clk_base),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_di       (cmd_di),
        .cmd_wc       (cmd_wc),
        .cmd_long     (cmd_long),
        .cmd_hs       (cmd_hs),
        .cmd_last     (cmd_last),
        .cmd_dummy    (cmd_dummy),
        .pl_valid     (pl_valid),
        .pl_ready     (pl_ready),
        .pl_data      (pl_data),
        .lane_data    (lane_data),
        .lane_write   (lane_write),
        .lane_type    (lane_type),
        .lane_eof     (lane_eof),
        .lane_dummy   (lane_dummy),
        .lane_ready   (lane_ready),
        .busy         (busy),
        .err_underrun (err_underrun)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] got_data[$];
    logic [2:0] got_flags[$];  // {dummy, eof, type}
    logic [7:0] exp_data[0:15];
    logic [7:0] pl_mem[0:15];
    int         pl_len;
    int         underruns, bad_lw, bad_cr, bad_pr;
    bit         timed_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] di, input logic [15:0] wc, input logic lng,
                            input logic hs, input logic last, input logic dmy);
        @(negedge clk_base);
        cmd_di    = di;
        cmd_wc    = wc;
        cmd_long  = lng;
        cmd_hs    = hs;
        cmd_last  = last;
        cmd_dummy = dmy;
        cmd_valid = 1'b1;
        #1;
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk_base);
        #1;
        cmd_valid = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    // Drive the lane/payload side until nbytes have been written (or the budget runs out).
    task automatic run_bytes(input int nbytes, input bit lng, input int wc, input int stall_at,
                             input int stall_len, input bit toggle, input bit full);
        int idx       = 0;
        int cyc       = 0;
        int stall_cnt = 0;
        int n;
        bit stalling;
        got_data.delete();
        got_flags.delete();
        underruns = 0;
        bad_lw    = 0;
        bad_cr    = 0;
        bad_pr    = 0;
        timed_out = 0;
        while (got_data.size() < nbytes) begin
            if (cyc >= 300) begin
                timed_out = 1;
                break;
            end
            @(negedge clk_base);
            cyc++;
            lane_ready = toggle ? cyc[0] : 1'b1;
            stalling   = (idx == stall_at) && (stall_cnt < stall_len);
            pl_valid   = (idx < pl_len) && !stalling;
            pl_data    = (idx < pl_len) ? pl_mem[idx] : 8'h00;
            #1;
            n = got_data.size();
            if (stalling) stall_cnt++;
            if (err_underrun) underruns++;
            if (lane_write && !lane_ready) bad_lw++;
            if (pl_ready !== (lane_ready && lng && n >= 4 && n < 4 + wc)) bad_pr++;
            if (cmd_ready !== (lane_write && full && n == nbytes - 1)) bad_cr++;
            if (lane_write) begin
                got_data.push_back(lane_data);
                got_flags.push_back({lane_dummy, lane_eof, lane_type});
            end
            if (pl_valid && pl_ready) idx++;
        end
        @(negedge clk_base);
        pl_valid   = 1'b0;
        lane_ready = 1'b1;
    endtask

    task automatic check_packet(input string name, input int n, input logic hs,
                                input logic last, input logic dmy);
        logic [2:0] ef;
        check($sformatf("%s_timeout", name), timed_out, 0);
        check($sformatf("%s_count", name), got_data.size(), n);
        check($sformatf("%s_write_no_ready", name), bad_lw, 0);
        check($sformatf("%s_cmd_ready", name), bad_cr, 0);
        check($sformatf("%s_pl_ready", name), bad_pr, 0);
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            ef = {dmy, (i == n - 1) && (last || dmy), hs};
            check($sformatf("%s_data%0d", name, i), got_data[i], exp_data[i]);
            check($sformatf("%s_flags%0d", name, i), got_flags[i], ef);
        end
    endtask

    task automatic load_long9();
        exp_data[0] = 8'h39;
        exp_data[1] = 8'h09;
        exp_data[2] = 8'h00;
        exp_data[3] = 8'h30;
        for (int i = 0; i < 9; i++) exp_data[4 + i] = 8'h31 + 8'(i);
        exp_data[13] = 8'h91;
        exp_data[14] = 8'h6F;
        pl_len = 9;
    endtask

    task automatic load_short();
        exp_data[0] = 8'h01;
        exp_data[1] = 8'h00;
        exp_data[2] = 8'h00;
        exp_data[3] = 8'h07;
        pl_len = 0;
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_di     = 8'h00;
        cmd_wc     = 16'h0000;
        cmd_long   = 1'b0;
        cmd_hs     = 1'b0;
        cmd_last   = 1'b0;
        cmd_dummy  = 1'b0;
        pl_valid   = 1'b0;
        pl_data    = 8'h00;
        lane_ready = 1'b1;
        pl_len     = 0;
        for (int i = 0; i < 16; i++) pl_mem[i] = 8'h31 + 8'(i);

        // Reset state
        repeat (2) @(negedge clk_base);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_pl_ready", pl_ready, 0);
        check("rst_lane_write", lane_write, 0);
        check("rst_lane_data", lane_data, 0);
        check("rst_lane_flags", {lane_type, lane_eof, lane_dummy}, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", err_underrun, 0);
        reset = 1'b0;

        // Short packet
        load_short();
        send_cmd(8'h01, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        run_bytes(4, 1'b0, 0, -1, 0, 1'b0, 1'b1);
        check_packet("short", 4, 1'b1, 1'b1, 1'b0);
        #1;
        check("short_idle", busy, 0);

        // Long packet, 9 bytes, reference CRC
        load_long9();
        send_cmd(8'h39, 16'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        run_bytes(15, 1'b1, 9, -1, 0, 1'b0, 1'b1);
        check_packet("long9", 15, 1'b1, 1'b1, 1'b0);
        check("long9_underrun", underruns, 0);
        #1;
        check("long9_idle", busy, 0);

        // Long packet with empty payload, LP, not last
        exp_data[0] = 8'h39;
        exp_data[1] = 8'h00;
        exp_data[2] = 8'h00;
        exp_data[3] = 8'h0F;
        exp_data[4] = 8'hFF;
        exp_data[5] = 8'hFF;
        pl_len = 0;
        send_cmd(8'h39, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_bytes(6, 1'b1, 0, -1, 0, 1'b0, 1'b1);
        check_packet("wc0", 6, 1'b0, 1'b0, 1'b0);

        // Payload stall of three cycles mid-payload
        load_long9();
        send_cmd(8'h39, 16'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        run_bytes(15, 1'b1, 9, 4, 3, 1'b0, 1'b1);
        check_packet("stall", 15, 1'b1, 1'b1, 1'b0);
        check("stall_underruns", underruns, 3);

        // lane_ready toggling every other cycle
        load_long9();
        send_cmd(8'h39, 16'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        run_bytes(15, 1'b1, 9, -1, 0, 1'b1, 1'b1);
        check_packet("toggle", 15, 1'b1, 1'b1, 1'b0);

        // Dummy byte
        exp_data[0] = 8'h00;
        pl_len = 0;
        send_cmd(8'hAA, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1);
        run_bytes(1, 1'b0, 0, -1, 0, 1'b0, 1'b1);
        check_packet("dummy", 1, 1'b1, 1'b0, 1'b1);
        #1;
        check("dummy_idle", busy, 0);

        // Reset during payload
        load_long9();
        send_cmd(8'h39, 16'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        run_bytes(6, 1'b1, 9, -1, 0, 1'b0, 1'b0);
        check("rstmid_busy_before", busy, 1);
        pl_valid = 1'b1;
        reset    = 1'b1;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_lane_write", lane_write, 0);
        check("rstmid_cmd_ready", cmd_ready, 1);
        check("rstmid_pl_ready", pl_ready, 0);
        @(negedge clk_base);
        reset    = 1'b0;
        pl_valid = 1'b0;
        #1;
        check("rstmid_no_write", lane_write, 0);

        load_short();
        send_cmd(8'h01, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        run_bytes(4, 1'b0, 0, -1, 0, 1'b0, 1'b1);
        check_packet("after_rst", 4, 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
